// File: rtl/cache_pkg.sv
// Shared cache/pmem types: line and beat containers plus the line adapter state encoding.
package cache_pkg;

  localparam int unsigned LINE_BITS   = 256;
  localparam int unsigned BEAT_BITS   = 64;
  localparam int unsigned BEATS       = LINE_BITS / BEAT_BITS;
  localparam int unsigned OFFSET_BITS = $clog2(LINE_BITS / 8);

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [BEAT_BITS-1:0] beat_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} pmem_adapter_state_t;

endpackage

// File: rtl/pmem_line_adapter.sv
// Serves one cache line fill or writeback as a 4-beat burst to main memory and reports
// completion with a one-cycle line_resp_o pulse.
module pmem_line_adapter
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_read_i,
  input  logic                  line_write_i,
  input  logic [ADDR_WIDTH-1:0] line_addr_i,
  input  logic [LINE_WIDTH-1:0] line_wdata_i,
  output logic [LINE_WIDTH-1:0] line_rdata_o,
  output logic                  line_resp_o,
  output logic                  burst_read_o,
  output logic                  burst_write_o,
  output logic [ADDR_WIDTH-1:0] burst_addr_o,
  output logic [BEAT_WIDTH-1:0] burst_wdata_o,
  input  logic [BEAT_WIDTH-1:0] burst_rdata_i,
  input  logic                  burst_resp_i
);

  localparam int unsigned Beats = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CntW  = $clog2(Beats);
  localparam int unsigned OffW  = $clog2(LINE_WIDTH / 8);

  pmem_adapter_state_t   state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        // Writeback has priority; a simultaneous fill stays pending for the next IDLE.
        if (line_write_i) begin
          addr_d  = {line_addr_i[ADDR_WIDTH-1:OffW], OffW'(0)};
          line_d  = line_wdata_i;
          state_d = WRITE;
        end else if (line_read_i) begin
          addr_d  = {line_addr_i[ADDR_WIDTH-1:OffW], OffW'(0)};
          state_d = READ;
        end
      end
      READ: begin
        if (burst_resp_i) begin
          line_d[int'(cnt_q) * int'(BEAT_WIDTH) +: BEAT_WIDTH] = burst_rdata_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(Beats - 1)) begin
            rdata_d = line_d;
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (burst_resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(Beats - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only.
  always_comb begin
    burst_read_o  = (state_q == READ);
    burst_write_o = (state_q == WRITE);
    burst_addr_o  = (state_q == READ || state_q == WRITE) ? addr_q : '0;
    burst_wdata_o = '0;
    if (state_q == WRITE) begin
      burst_wdata_o = line_q[int'(cnt_q) * int'(BEAT_WIDTH) +: BEAT_WIDTH];
    end
    line_resp_o  = (state_q == DONE);
    line_rdata_o = rdata_q;
  end

endmodule

// File: tb/tb_pmem_line_adapter.sv
// Directed plus randomized bench for pmem_line_adapter against a transaction-level model.
module tb_pmem_line_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read_i, line_write_i;
  logic [31:0]  line_addr_i;
  logic [255:0] line_wdata_i, line_rdata_o;
  logic         line_resp_o, burst_read_o, burst_write_o;
  logic [31:0]  burst_addr_o;
  logic [63:0]  burst_wdata_o, burst_rdata_i;
  logic         burst_resp_i;

  int vectors = 0;
  int miscompares = 0;
  logic [255:0] last_rdata;

  pmem_line_adapter dut (
    .clk          (clk),
    .rst          (rst),
    .line_read_i  (line_read_i),
    .line_write_i (line_write_i),
    .line_addr_i  (line_addr_i),
    .line_wdata_i (line_wdata_i),
    .line_rdata_o (line_rdata_o),
    .line_resp_o  (line_resp_o),
    .burst_read_o (burst_read_o),
    .burst_write_o(burst_write_o),
    .burst_addr_o (burst_addr_o),
    .burst_wdata_o(burst_wdata_o),
    .burst_rdata_i(burst_rdata_i),
    .burst_resp_i (burst_resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, "_rd"}, 256'(burst_read_o), 256'(0));
    chk({tag, "_wr"}, 256'(burst_write_o), 256'(0));
    chk({tag, "_resp"}, 256'(line_resp_o), 256'(0));
    chk({tag, "_addr"}, 256'(burst_addr_o), 256'(0));
    chk({tag, "_wdata"}, 256'(burst_wdata_o), 256'(0));
    chk({tag, "_rdata"}, line_rdata_o, last_rdata);
  endtask

  task automatic busy_chk(input bit wr, input logic [31:0] al, input logic [63:0] slice);
    chk("busy_rd", 256'(burst_read_o), 256'(!wr));
    chk("busy_wr", 256'(burst_write_o), 256'(wr));
    chk("busy_addr", 256'(burst_addr_o), 256'(al));
    chk("busy_wdata", 256'(burst_wdata_o), wr ? 256'(slice) : 256'(0));
    chk("busy_resp", 256'(line_resp_o), 256'(0));
    chk("busy_rdata", line_rdata_o, last_rdata);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after DONE (idle again).
  task automatic txn(input bit wr, input bit both, input logic [31:0] addr,
                     input logic [255:0] data, input int glo, input int ghi,
                     input bit keep_read, input logic [31:0] next_addr);
    logic [31:0] al;
    int g;
    al = addr & 32'hFFFF_FFE0;
    line_write_i = wr;
    line_read_i  = !wr || both;
    line_addr_i  = addr;
    line_wdata_i = data;
    @(negedge clk);
    // Request inputs wander mid-burst; the latched copies must be used.
    line_addr_i  = $urandom;
    line_wdata_i = rnd_line();
    for (int i = 0; i < 4; i++) begin
      g = int'($urandom_range(ghi, glo));
      repeat (g) begin
        burst_resp_i  = 1'b0;
        burst_rdata_i = {$urandom, $urandom};
        busy_chk(wr, al, data[i*64 +: 64]);
        @(negedge clk);
      end
      burst_resp_i  = 1'b1;
      burst_rdata_i = data[i*64 +: 64];
      busy_chk(wr, al, data[i*64 +: 64]);
      @(negedge clk);
    end
    burst_resp_i = 1'b0;
    if (!wr) last_rdata = data;
    chk("done_resp", 256'(line_resp_o), 256'(1));
    chk("done_rd", 256'(burst_read_o), 256'(0));
    chk("done_wr", 256'(burst_write_o), 256'(0));
    chk("done_rdata", line_rdata_o, last_rdata);
    line_write_i = 1'b0;
    line_read_i  = keep_read;
    line_addr_i  = next_addr;
    @(negedge clk);
    idle_chk("post");
  endtask

  initial begin
    rst           = 1'b1;
    line_read_i   = 1'b0;
    line_write_i  = 1'b0;
    line_addr_i   = '0;
    line_wdata_i  = '0;
    burst_rdata_i = '0;
    burst_resp_i  = 1'b0;
    last_rdata    = '0;
    repeat (2) @(negedge clk);
    idle_chk("reset");
    rst = 1'b0;
    @(negedge clk);
    idle_chk("idle");

    // Basic fill, back-to-back beats: resp lands exactly N+5.
    txn(1'b0, 1'b0, 32'h0000_1234,
        {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0, 1'b0, '0);

    // Writeback with 2-cycle gaps between beats.
    txn(1'b1, 1'b0, 32'h0000_00E0,
        {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
         64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0}, 2, 2, 1'b0, '0);

    // Both requests high: write first, read stays pending and follows.
    txn(1'b1, 1'b1, 32'h0000_0040, rnd_line(), 0, 1, 1'b1, 32'h0000_0040);
    txn(1'b0, 1'b0, 32'h0000_0040, rnd_line(), 0, 1, 1'b0, '0);

    // Reset after two beats of a fill aborts it.
    line_read_i = 1'b1;
    line_addr_i = 32'h0000_3000;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      burst_resp_i  = 1'b1;
      burst_rdata_i = {$urandom, $urandom};
      @(negedge clk);
    end
    burst_resp_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    last_rdata  = '0;
    idle_chk("async_rst");
    line_read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      idle_chk("after_rst");
    end
    txn(1'b0, 1'b0, 32'h0000_3004, rnd_line(), 0, 0, 1'b0, '0);

    // Stray memory handshakes while idle are ignored.
    burst_resp_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      idle_chk("stray");
    end
    burst_resp_i = 1'b0;
    txn(1'b0, 1'b0, 32'h0000_0ABC, rnd_line(), 0, 2, 1'b0, '0);

    // Request held past resp becomes a fresh transaction from IDLE.
    txn(1'b0, 1'b0, 32'h0000_0100, rnd_line(), 0, 0, 1'b1, 32'h0000_0200);
    txn(1'b0, 1'b0, 32'h0000_0200, rnd_line(), 0, 0, 1'b0, '0);

    for (int n = 0; n < 24; n++) begin
      txn(1'($urandom_range(1, 0)), 1'b0, $urandom, rnd_line(), 0, 2, 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
